// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states,
// instruction classes and datapath select values.
package ctrl_pkg;

   localparam int unsigned OPCODE_W = 7;
   localparam int unsigned FUNCT3_W = 3;
   localparam int unsigned WB_SEL_W = 2;

   localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
   localparam logic [OPCODE_W-1:0] OP_IALU   = 7'b0010011;
   localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;

   typedef enum logic [2:0] {
      S_RST,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } state_t;

   typedef enum logic [2:0] {
      CL_R,
      CL_IALU,
      CL_LOAD,
      CL_STORE,
      CL_BRANCH,
      CL_JAL,
      CL_LUI,
      CL_NONE
   } inst_class_t;

   localparam logic [WB_SEL_W-1:0] WB_ALU = 2'd0;
   localparam logic [WB_SEL_W-1:0] WB_MEM = 2'd1;
   localparam logic [WB_SEL_W-1:0] WB_PC4 = 2'd2;
   localparam logic [WB_SEL_W-1:0] WB_IMM = 2'd3;

   localparam logic PC_SEL_PC4 = 1'b0;
   localparam logic PC_SEL_IMM = 1'b1;

   localparam logic ADDR_PC  = 1'b0;
   localparam logic ADDR_ALU = 1'b1;

   localparam logic ALU_B_RS2 = 1'b0;
   localparam logic ALU_B_IMM = 1'b1;

   // ALU operand B comes from the immediate for I-ALU and address generation.
   function automatic logic uses_imm(input inst_class_t cls);
      return (cls == CL_IALU) || (cls == CL_LOAD) || (cls == CL_STORE);
   endfunction

   function automatic logic [WB_SEL_W-1:0] wb_sel_for(input inst_class_t cls);
      logic [WB_SEL_W-1:0] sel;
      case (cls)
         CL_LOAD: sel = WB_MEM;
         CL_JAL:  sel = WB_PC4;
         CL_LUI:  sel = WB_IMM;
         default: sel = WB_ALU;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct3 classifier; flags unsupported opcodes and
// reserved funct3 encodings of branch, load and store.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [OPCODE_W-1:0] opcode_i,
   input  logic [FUNCT3_W-1:0] funct3_i,
   output inst_class_t         cls_o,
   output logic                illegal_o
);

   always_comb begin
      cls_o     = CL_NONE;
      illegal_o = 1'b1;
      case (opcode_i)
         OP_R: begin
            cls_o     = CL_R;
            illegal_o = 1'b0;
         end
         OP_IALU: begin
            cls_o     = CL_IALU;
            illegal_o = 1'b0;
         end
         OP_LOAD: begin
            cls_o     = CL_LOAD;
            illegal_o = (funct3_i == 3'b011) || (funct3_i == 3'b110) ||
                        (funct3_i == 3'b111);
         end
         OP_STORE: begin
            cls_o     = CL_STORE;
            illegal_o = (funct3_i >= 3'b011);
         end
         OP_BRANCH: begin
            cls_o     = CL_BRANCH;
            illegal_o = (funct3_i == 3'b010) || (funct3_i == 3'b011);
         end
         OP_JAL: begin
            cls_o     = CL_JAL;
            illegal_o = 1'b0;
         end
         OP_LUI: begin
            cls_o     = CL_LUI;
            illegal_o = 1'b0;
         end
         default: begin
            cls_o     = CL_NONE;
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// drives the datapath selects combinationally from state and counts retirements.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [FUNCT3_W-1:0] funct3,
   input  logic                br_taken,
   input  logic                mem_ack,
   output logic                mem_req,
   output logic                mem_we,
   output logic                addr_sel,
   output logic                ir_we,
   output logic                alu_b_sel,
   output logic                pc_we,
   output logic                pc_sel,
   output logic                reg_we,
   output logic [WB_SEL_W-1:0] wb_sel,
   output logic                illegal,
   output logic [CNT_W-1:0]    retired
);

   state_t           state_q;
   inst_class_t      cls;
   logic             dec_illegal;
   logic [CNT_W-1:0] retired_q;
   logic [CNT_W-1:0] retired_d;

   ctrl_decode u_decode (
      .opcode_i  (opcode),
      .funct3_i  (funct3),
      .cls_o     (cls),
      .illegal_o (dec_illegal)
   );

   // State sequencing; the class only matters from DECODE on, once IR holds the new word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_RST;
      end else begin
         case (state_q)
            S_RST:    state_q <= S_FETCH;
            S_FETCH:  if (mem_ack) state_q <= S_DECODE;
            S_DECODE: state_q <= dec_illegal ? S_TRAP : S_EXEC;
            S_EXEC: begin
               case (cls)
                  CL_BRANCH:         state_q <= S_FETCH;
                  CL_LOAD, CL_STORE: state_q <= S_MEM;
                  default:           state_q <= S_WB;
               endcase
            end
            S_MEM: begin
               if (mem_ack) state_q <= (cls == CL_STORE) ? S_FETCH : S_WB;
            end
            S_WB:     state_q <= S_FETCH;
            S_TRAP:   state_q <= S_TRAP;
            default:  state_q <= S_RST;
         endcase
      end
   end

   // Datapath controls decoded straight from state; RST and TRAP leave every enable low.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = ADDR_PC;
      ir_we     = 1'b0;
      alu_b_sel = ALU_B_RS2;
      pc_we     = 1'b0;
      pc_sel    = PC_SEL_PC4;
      reg_we    = 1'b0;
      wb_sel    = WB_ALU;
      illegal   = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req  = 1'b1;
            addr_sel = ADDR_PC;
            ir_we    = mem_ack;
         end
         S_EXEC: begin
            alu_b_sel = uses_imm(cls) ? ALU_B_IMM : ALU_B_RS2;
            if (cls == CL_BRANCH) begin
               pc_we  = 1'b1;
               pc_sel = br_taken ? PC_SEL_IMM : PC_SEL_PC4;
            end
         end
         S_MEM: begin
            mem_req   = 1'b1;
            addr_sel  = ADDR_ALU;
            alu_b_sel = ALU_B_IMM;
            mem_we    = (cls == CL_STORE);
            if (mem_ack && (cls == CL_STORE)) begin
               pc_we  = 1'b1;
               pc_sel = PC_SEL_PC4;
            end
         end
         S_WB: begin
            reg_we = 1'b1;
            pc_we  = 1'b1;
            wb_sel = wb_sel_for(cls);
            pc_sel = (cls == CL_JAL) ? PC_SEL_IMM : PC_SEL_PC4;
         end
         S_TRAP: begin
            illegal = 1'b1;
         end
         default: begin
            illegal = 1'b0;
         end
      endcase
   end

   // One PC update per instruction, so pc_we doubles as the retire strobe.
   always_comb begin
      retired_d = retired_q;
      if (pc_we) retired_d = retired_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired_q <= '0;
      end else begin
         retired_q <= retired_d;
      end
   end

   assign retired = retired_q;

   a_ir_excl: assert property (@(posedge clk) disable iff (rst)
      !(ir_we && (pc_we || reg_we)));
   a_reg_with_pc: assert property (@(posedge clk) disable iff (rst)
      reg_we |-> pc_we);
   a_we_qual: assert property (@(posedge clk) disable iff (rst)
      mem_we |-> mem_req);
   a_trap_sticky: assert property (@(posedge clk) disable iff (rst)
      illegal |=> illegal);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control vectors for each
// instruction class, stalls, traps and asynchronous reset.
module tb_multicycle_ctrl;

   localparam int unsigned CNT_W = 32;

   // Output vector layout: {req, we, asel, ir_we}_{bsel, pc_we, pc_sel, reg_we}_{wb_sel}_{illegal}
   localparam logic [10:0] O_ZERO = 11'b0000_0000_00_0;
   localparam logic [10:0] F_WAIT = 11'b1000_0000_00_0;
   localparam logic [10:0] F_ACK  = 11'b1001_0000_00_0;
   localparam logic [10:0] X_IMM  = 11'b0000_1000_00_0;
   localparam logic [10:0] X_BRT  = 11'b0000_0110_00_0;
   localparam logic [10:0] X_BRN  = 11'b0000_0100_00_0;
   localparam logic [10:0] M_LD   = 11'b1010_1000_00_0;
   localparam logic [10:0] M_ST   = 11'b1110_1000_00_0;
   localparam logic [10:0] M_STA  = 11'b1110_1100_00_0;
   localparam logic [10:0] W_ALU  = 11'b0000_0101_00_0;
   localparam logic [10:0] W_LD   = 11'b0000_0101_01_0;
   localparam logic [10:0] W_JAL  = 11'b0000_0111_10_0;
   localparam logic [10:0] W_LUI  = 11'b0000_0101_11_0;
   localparam logic [10:0] TRAPV  = 11'b0000_0000_00_1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic             br_taken = 1'b0;
   logic             mem_ack = 1'b0;
   logic             mem_req, mem_we, addr_sel, ir_we, alu_b_sel;
   logic             pc_we, pc_sel, reg_we, illegal;
   logic [1:0]       wb_sel;
   logic [CNT_W-1:0] retired;
   logic [10:0]      outs;

   logic [31:0]      mem_instr = 32'h0;
   logic [31:0]      ir = 32'h0;
   logic [CNT_W-1:0] exp_ret = '0;
   int               checks = 0;
   int               errors = 0;

   multicycle_ctrl #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .opcode    (opcode),
      .funct3    (funct3),
      .br_taken  (br_taken),
      .mem_ack   (mem_ack),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .addr_sel  (addr_sel),
      .ir_we     (ir_we),
      .alu_b_sel (alu_b_sel),
      .pc_we     (pc_we),
      .pc_sel    (pc_sel),
      .reg_we    (reg_we),
      .wb_sel    (wb_sel),
      .illegal   (illegal),
      .retired   (retired)
   );

   always #5 clk = ~clk;

   // Instruction register model fed from the bench's memory word.
   always @(posedge clk) if (ir_we) ir <= mem_instr;

   assign opcode = ir[6:0];
   assign funct3 = ir[14:12];
   assign outs   = {mem_req, mem_we, addr_sel, ir_we, alu_b_sel, pc_we, pc_sel,
                    reg_we, wb_sel, illegal};

   task automatic cyc(input logic ack, input logic br);
      @(negedge clk);
      mem_ack  = ack;
      br_taken = br;
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst     = 1'b1;
      mem_ack = 1'b0;
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, 1'b1);
         checks++;
         if (outs !== O_ZERO || retired !== '0) begin
            errors++;
            $display("FAIL reset_hold cyc%0d outs=%b retired=%0d exp outs=%b retired=0",
                     i, outs, retired, O_ZERO);
         end
      end
      release_reset();
      checks++;
      if (outs !== O_ZERO) begin
         errors++;
         $display("FAIL reset_rst_state outs=%b exp=%b", outs, O_ZERO);
      end
      cyc(1'b0, 1'b0);
      checks++;
      if (outs !== F_WAIT) begin
         errors++;
         $display("FAIL reset_first_fetch outs=%b exp=%b", outs, F_WAIT);
      end
   endtask

   task automatic test_alu_group();
      logic [31:0] ins [4] = '{32'h002081B3, 32'h00108093, 32'h008000EF, 32'h123450B7};
      logic [10:0] xv  [4] = '{O_ZERO, X_IMM, O_ZERO, O_ZERO};
      logic [10:0] wv  [4] = '{W_ALU, W_ALU, W_JAL, W_LUI};
      logic [10:0] exp [4];
      logic        a;
      for (int k = 0; k < 4; k++) begin
         mem_instr = ins[k];
         exp = '{F_ACK, O_ZERO, xv[k], wv[k]};
         a = (k % 2 == 1);
         for (int i = 0; i < 4; i++) begin
            cyc((i == 0) ? 1'b1 : a, 1'b0);
            checks++;
            if (outs !== exp[i]) begin
               errors++;
               $display("FAIL alu%0d cyc%0d outs=%b exp=%b", k, i, outs, exp[i]);
            end
         end
         exp_ret++;
         cyc(1'b0, 1'b0);
         checks++;
         if (outs !== F_WAIT || retired !== exp_ret) begin
            errors++;
            $display("FAIL alu%0d_retire outs=%b retired=%0d exp outs=%b retired=%0d",
                     k, outs, retired, F_WAIT, exp_ret);
         end
      end
   endtask

   task automatic test_load();
      logic [10:0] exp [8] = '{F_ACK, O_ZERO, X_IMM, M_LD, M_LD, M_LD, M_LD, W_LD};
      logic        ack [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [10:0] ex2 [5] = '{F_ACK, O_ZERO, X_IMM, M_LD, W_LD};
      logic        ak2 [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      mem_instr = 32'h0000A103;
      for (int i = 0; i < 8; i++) begin
         cyc(ack[i], 1'b0);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL lw cyc%0d outs=%b exp=%b", i, outs, exp[i]);
         end
      end
      exp_ret++;
      // LHU: funct3=101 sits between the reserved load encodings but is legal.
      mem_instr = 32'h0000D103;
      for (int i = 0; i < 5; i++) begin
         cyc(ak2[i], 1'b0);
         checks++;
         if (outs !== ex2[i]) begin
            errors++;
            $display("FAIL lhu cyc%0d outs=%b exp=%b", i, outs, ex2[i]);
         end
      end
      exp_ret++;
      cyc(1'b0, 1'b0);
      checks++;
      if (outs !== F_WAIT || retired !== exp_ret) begin
         errors++;
         $display("FAIL load_retire outs=%b retired=%0d exp outs=%b retired=%0d",
                  outs, retired, F_WAIT, exp_ret);
      end
   endtask

   task automatic test_store();
      logic [10:0] exp [6] = '{F_WAIT, F_ACK, O_ZERO, X_IMM, M_ST, M_STA};
      logic        ack [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      mem_instr = 32'h0020A023;
      for (int i = 0; i < 6; i++) begin
         cyc(ack[i], 1'b0);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL sw cyc%0d outs=%b exp=%b", i, outs, exp[i]);
         end
      end
      exp_ret++;
      cyc(1'b0, 1'b0);
      checks++;
      if (outs !== F_WAIT || retired !== exp_ret) begin
         errors++;
         $display("FAIL sw_retire outs=%b retired=%0d exp outs=%b retired=%0d",
                  outs, retired, F_WAIT, exp_ret);
      end
   endtask

   task automatic test_branch();
      logic        br [2] = '{1'b1, 1'b0};
      logic [10:0] xb [2] = '{X_BRT, X_BRN};
      logic [10:0] exp [3];
      mem_instr = 32'h00208463;
      for (int k = 0; k < 2; k++) begin
         exp = '{F_ACK, O_ZERO, xb[k]};
         for (int i = 0; i < 3; i++) begin
            cyc((i == 0) ? 1'b1 : 1'b0, br[k]);
            checks++;
            if (outs !== exp[i]) begin
               errors++;
               $display("FAIL beq%0d cyc%0d outs=%b exp=%b", k, i, outs, exp[i]);
            end
         end
         exp_ret++;
         cyc(1'b0, br[k]);
         checks++;
         if (outs !== F_WAIT || retired !== exp_ret) begin
            errors++;
            $display("FAIL beq%0d_retire outs=%b retired=%0d exp outs=%b retired=%0d",
                     k, outs, retired, F_WAIT, exp_ret);
         end
      end
   endtask

   task automatic test_reset_mid_mem();
      logic [10:0] exp [4] = '{F_ACK, O_ZERO, X_IMM, M_LD};
      mem_instr = 32'h0000A103;
      for (int i = 0; i < 4; i++) begin
         cyc((i == 0) ? 1'b1 : 1'b0, 1'b0);
         checks++;
         if (outs !== exp[i]) begin
            errors++;
            $display("FAIL midrst_pre cyc%0d outs=%b exp=%b", i, outs, exp[i]);
         end
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (outs !== O_ZERO || retired !== '0) begin
         errors++;
         $display("FAIL midrst_async outs=%b retired=%0d exp outs=%b retired=0",
                  outs, retired, O_ZERO);
      end
      exp_ret = '0;
      release_reset();
      cyc(1'b0, 1'b0);
      checks++;
      if (outs !== F_WAIT) begin
         errors++;
         $display("FAIL midrst_fetch outs=%b exp=%b", outs, F_WAIT);
      end
   endtask

   task automatic test_trap();
      logic [CNT_W-1:0] frozen;
      // One retirement first so the frozen counter is non-zero.
      mem_instr = 32'h002081B3;
      for (int i = 0; i < 4; i++) cyc((i == 0) ? 1'b1 : 1'b0, 1'b0);
      exp_ret++;
      frozen = exp_ret;
      mem_instr = 32'h00000017;
      cyc(1'b1, 1'b0);
      checks++;
      if (outs !== F_ACK || retired !== frozen) begin
         errors++;
         $display("FAIL auipc_fetch outs=%b retired=%0d exp outs=%b retired=%0d",
                  outs, retired, F_ACK, frozen);
      end
      cyc(1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         cyc(1'(i % 2), 1'b1);
         checks++;
         if (outs !== TRAPV || retired !== frozen) begin
            errors++;
            $display("FAIL trap_hold cyc%0d outs=%b retired=%0d exp outs=%b retired=%0d",
                     i, outs, retired, TRAPV, frozen);
         end
      end
      apply_reset();
      checks++;
      if (outs !== O_ZERO || retired !== '0) begin
         errors++;
         $display("FAIL trap_reset outs=%b retired=%0d exp outs=%b retired=0",
                  outs, retired, O_ZERO);
      end
      exp_ret = '0;
      release_reset();
   endtask

   task automatic test_illegal_funct3();
      logic [31:0] ins [3] = '{32'h0000B103, 32'h0020B023, 32'h0020A463};
      for (int k = 0; k < 3; k++) begin
         mem_instr = ins[k];
         cyc(1'b0, 1'b0);
         checks++;
         if (outs !== F_WAIT) begin
            errors++;
            $display("FAIL ill%0d_fetch outs=%b exp=%b", k, outs, F_WAIT);
         end
         cyc(1'b1, 1'b0);
         cyc(1'b0, 1'b0);
         for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0);
            checks++;
            if (outs !== TRAPV || retired !== '0) begin
               errors++;
               $display("FAIL ill%0d_trap cyc%0d outs=%b retired=%0d exp outs=%b retired=0",
                        k, i, outs, retired, TRAPV);
            end
         end
         apply_reset();
         release_reset();
      end
   endtask

   initial begin
      test_reset();
      test_alu_group();
      test_load();
      test_store();
      test_branch();
      test_reset_mid_mem();
      test_trap();
      test_illegal_funct3();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle RV32I control FSM. It sequences fetch, decode, execute, memory and writeback over a shared single-port memory, register file, ALU and immediate generator.
- Decodes the opcode and funct3 from the instruction register and drives all datapath selects and write enables.
- Counts retired instructions.
- Supported opcode set matches the immediate generator's decode (I-ALU, load, store, branch, JAL, LUI) plus R-type. Everything else traps.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- br_taken  in  1  branch comparator result, valid in EXEC
- mem_ack  in  1  memory completion, single-cycle pulse
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  store strobe, qualified by mem_req
- addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  instruction register load
- alu_b_sel  out  1  0 = rs2, 1 = imm
- pc_we  out  1  PC update
- pc_sel  out  1  0 = PC+4, 1 = PC+imm
- reg_we  out  1  register file write
- wb_sel  out  2  0 = ALU, 1 = mem data, 2 = PC+4, 3 = imm
- illegal  out  1  sticky trap flag
- retired  out  CNT_W  retired-instruction count

Behaviour:
- States: RST, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- While rst is high, state = RST and every output is 0, including retired. RST moves to FETCH on the first clock after reset deasserts.
- Outputs are a function of state, decoded class and mem_ack. There is no output register.
- FETCH
  - mem_req=1, addr_sel=0.
  - On mem_ack: ir_we=1 that cycle, next state DECODE. Otherwise stay.
- DECODE
  - Single cycle.
  - Illegal -> TRAP, otherwise EXEC.
  - Illegal means: opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 0110111}, branch funct3 ∈ {010, 011}, load funct3 ∈ {011, 110, 111}, or store funct3 ≥ 011.
- EXEC
  - alu_b_sel=1 for I-ALU, load and store; 0 otherwise.
  - Branch: pc_we=1, pc_sel=br_taken, next FETCH.
  - Load/store: next MEM.
  - All other classes: next WB.
- MEM
  - mem_req=1, addr_sel=1, alu_b_sel=1, mem_we=1 for stores.
  - On mem_ack: a store also asserts pc_we=1, pc_sel=0 and goes to FETCH; a load goes to WB.
  - Otherwise stay, with outputs held stable.
- WB
  - reg_we=1, pc_we=1.
  - wb_sel: 0 for R/I-ALU, 1 for load, 2 for JAL, 3 for LUI.
  - pc_sel=1 for JAL, else 0.
  - Next FETCH.
- TRAP: illegal=1, all enables 0, held until reset.
- Latency, with immediate ack:
  - Branch: 3 cycles.
  - R-type, I-ALU, LUI, JAL: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle without ack adds one.
- retired increments by 1 on every cycle with pc_we=1 and wraps modulo 2^CNT_W. It never increments in TRAP.
- mem_ack outside FETCH or MEM is ignored.
- Reset asserted in any state, including mid-request, forces RST and drops all outputs asynchronously.
- Exactly one pc_we pulse per instruction.
- reg_we, ir_we and pc_we are never asserted in the same cycle except reg_we with pc_we in WB.

Decomposition:
- ctrl_pkg holds:
  - opcode localparams (OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI);
  - state enum state_t;
  - wb_sel encodings (WB_ALU, WB_MEM, WB_PC4, WB_IMM) and pc_sel encodings.
- One sub-module, ctrl_decode: combinational opcode/funct3 to instruction class plus illegal bit. Instantiated once inside multicycle_ctrl.

Test Plan:
- ADD 0x002081B3 with ack in FETCH's first cycle -> FETCH, DECODE, EXEC, WB. Exactly one cycle of reg_we=1, wb_sel=0, pc_we=1, pc_sel=0; retired 0→1.
- LW 0x0000A103 with mem_ack delayed 3 cycles in MEM -> mem_req=1, addr_sel=1, mem_we=0 held for 4 MEM cycles, then WB with wb_sel=1; 8 cycles total.
- SW 0x0020A023 -> MEM with mem_we=1. On ack: pc_we=1, no reg_we, next FETCH.
- BEQ 0x00208463 with br_taken=1, then a second BEQ with br_taken=0 -> EXEC pc_we=1 with pc_sel=1, then pc_sel=0. reg_we never asserted.
- JAL 0x008000EF -> WB with wb_sel=2, pc_sel=1. LUI 0x123450B7 -> wb_sel=3.
- AUIPC 0x00000017 -> TRAP, illegal=1 held for 20 cycles with no enables and retired frozen. rst pulse mid-MEM -> all outputs 0 immediately; FETCH on the first clock after release.
